// File: rtl/bcd_convert_ctrl_pkg.sv
// Shared types and constants for the binary-to-BCD conversion sequencer.
// Used by bcd_convert_ctrl and bcd_blank (BCD_BLANK_LEADING_EN option).
package bcd_convert_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic [3:0]  BCD_BLANK   = 4'hF;
    localparam int unsigned DIV_LATENCY = 11;

    // Largest value representable in 'digits' decimal digits: 10^digits - 1.
    function automatic int unsigned max_value(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bcd_blank.sv
// Leading-zero blanker for packed BCD. Active only when BCD_BLANK_LEADING_EN is
// defined; otherwise a plain pass-through so the top netlist is identical in shape.
module bcd_blank
    import bcd_convert_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] digits_i,
    output logic [4*DIGITS-1:0] digits_o
);

`ifdef BCD_BLANK_LEADING_EN
    logic leading;

    // Walk down from the top digit; digit0 is always shown.
    always_comb begin
        digits_o = digits_i;
        leading  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (leading && (digits_i[4*i +: 4] == 4'h0)) begin
                digits_o[4*i +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign digits_o = digits_i;
`endif

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequencer driving the shared divide-by-10 unit to convert binary to packed BCD.
// Optional BCD_BLANK_LEADING_EN blanks leading zero digits (via bcd_blank).
module bcd_convert_ctrl
    import bcd_convert_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned VALUE_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  div_start,
    output logic [VALUE_W-1:0]    div_value,
    input  logic [9:0]            div_quotient,
    input  logic [3:0]            div_remainder,
    input  logic                  div_ready
);

    localparam int unsigned         DW        = 4 * DIGITS;
    localparam logic [VALUE_W-1:0]  MAX_VALUE = VALUE_W'(max_value(DIGITS));
    localparam logic [2:0]          LAST_CNT  = 3'(DIGITS);

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [DW-1:0]       digits_q, digits_d;
    logic [DW-1:0]       dreg_q, dreg_d;
    logic                div_start_q, div_start_d;
    logic [VALUE_W-1:0]  div_value_q, div_value_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DW-1:0]       dreg_shown;

    bcd_blank #(
        .DIGITS (DIGITS)
    ) u_blank (
        .digits_i (dreg_q),
        .digits_o (dreg_shown)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        digits_d    = digits_q;
        dreg_d      = dreg_q;
        div_start_d = 1'b0;
        div_value_d = div_value_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (value > MAX_VALUE) begin
                        overflow_d = 1'b1;
                        digits_d   = {DIGITS{4'h9}};
                        state_d    = ST_FINISH;
                    end else begin
                        overflow_d  = 1'b0;
                        div_value_d = value;
                        cnt_d       = 3'd0;
                        dreg_d      = '0;
                        div_start_d = 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ready) begin
                    // Remainders arrive ones-first, so shift in from the top.
                    dreg_d      = (dreg_q >> 4) | (DW'(div_remainder) << (DW - 4));
                    div_value_d = VALUE_W'(div_quotient);
                    cnt_d       = cnt_q + 3'd1;
                    if (cnt_d == LAST_CNT) begin
                        state_d = ST_FINISH;
                    end else begin
                        div_start_d = 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_FINISH: begin
                if (!overflow_q) begin
                    digits_d = dreg_shown;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            digits_q    <= '0;
            dreg_q      <= '0;
            div_start_q <= 1'b0;
            div_value_q <= '0;
            cnt_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            digits_q    <= digits_d;
            dreg_q      <= dreg_d;
            div_start_q <= div_start_d;
            div_value_q <= div_value_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign digits    = digits_q;
    assign div_start = div_start_q;
    assign div_value = div_value_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench for bcd_convert_ctrl with a behavioural divide-by-10 unit.
// Expected digits follow BCD_BLANK_LEADING_EN when that macro is defined.
module tb_bcd_convert_ctrl;
    import bcd_convert_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [13:0] value = '0;
    logic        busy, done, overflow, div_start;
    logic [15:0] digits;
    logic [13:0] div_value;
    logic [9:0]  div_q;
    logic [3:0]  div_r;
    logic        div_rdy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_div = 0;
    int dcnt;
    logic drun;

    always #5 clk = ~clk;

    bcd_convert_ctrl #(
        .DIGITS  (4),
        .VALUE_W (14)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .digits        (digits),
        .div_start     (div_start),
        .div_value     (div_value),
        .div_quotient  (div_q),
        .div_remainder (div_r),
        .div_ready     (div_rdy)
    );

    // Divider: ready drops on the load edge and rises DIV_LATENCY edges later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_rdy <= 1'b0;
            drun    <= 1'b0;
            dcnt    <= 0;
            div_q   <= '0;
            div_r   <= '0;
        end else if (div_start) begin
            div_q   <= 10'(div_value / 14'd10);
            div_r   <= 4'(div_value % 14'd10);
            div_rdy <= 1'b0;
            drun    <= 1'b1;
            dcnt    <= 1;
        end else if (drun) begin
            if (dcnt == DIV_LATENCY) begin
                div_rdy <= 1'b1;
                drun    <= 1'b0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst && div_start) n_div = n_div + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse and follow the conversion to done.
    task automatic run(input logic [13:0] v, input logic [15:0] exp_dig, input logic exp_ovf,
                       input int exp_lat, input int exp_ndiv, input bit poke);
        int lat;
        @(negedge clk);
        value = v;
        start = 1'b1;
        n_div = 0;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        check_eq("busy_accept", 32'(busy), 32'd1);
        check_eq("div_start_accept", 32'(div_start), 32'(!exp_ovf));
        if (!exp_ovf) check_eq("div_value_load", 32'(div_value), 32'(v));
        while (!done && lat < 200) begin
            // A start while in FINISH must be ignored.
            if (poke && lat == exp_lat - 1) begin
                start = 1'b1;
                value = 14'd0;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("digits", 32'(digits), 32'(exp_dig));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("div_start_count", 32'(n_div), 32'(exp_ndiv));
        check_eq("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("busy_after_done", 32'(busy), 32'd0);
    endtask

    logic [15:0] e0, e42, e5;
    int lat;
    int seen;

    initial begin
`ifdef BCD_BLANK_LEADING_EN
        e0  = 16'hFFF0;
        e42 = 16'hFF42;
        e5  = 16'hFFF5;
`else
        e0  = 16'h0000;
        e42 = 16'h0042;
        e5  = 16'h0005;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_digits", 32'(digits), 32'd0);
        check_eq("rst_div_start", 32'(div_start), 32'd0);
        check_eq("rst_div_value", 32'(div_value), 32'd0);
        rst = 1'b1;

        run(14'd1234, 16'h1234, 1'b0, 53, 4, 1'b0);
        run(14'd9999, 16'h9999, 1'b0, 53, 4, 1'b1);
        run(14'd0, e0, 1'b0, 53, 4, 1'b0);
        run(14'd10000, 16'h9999, 1'b1, 1, 0, 1'b0);
        run(14'd42, e42, 1'b0, 53, 4, 1'b0);
        run(14'd1000, 16'h1000, 1'b0, 53, 4, 1'b0);

        // start held high: one conversion, then a second accepted right after done.
        @(negedge clk);
        value = 14'd5;
        start = 1'b1;
        n_div = 0;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq("held_latency", 32'(lat), 32'd53);
        check_eq("held_div_count", 32'(n_div), 32'd4);
        check_eq("held_digits", 32'(digits), 32'(e5));
        @(negedge clk);
        start = 1'b0;
        check_eq("held_reaccept", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq("held_latency2", 32'(lat), 32'd53);
        check_eq("held_digits2", 32'(digits), 32'(e5));

        // Reset mid-conversion aborts with no done.
        @(negedge clk);
        value = 14'd5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_div_start", 32'(div_start), 32'd0);
        check_eq("abort_div_value", 32'(div_value), 32'd0);
        check_eq("abort_digits", 32'(digits), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_eq("abort_no_done", 32'(seen), 32'd0);
        run(14'd5678, 16'h5678, 1'b0, 53, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_convert_ctrl.md
Name: bcd_convert_ctrl

Overview:
- Sequencer that drives the shared divide-by-10 datapath to convert a 14-bit binary value (0..9999) into four packed BCD digits for the seven-segment display path.
- Issues one divide per digit, least-significant digit first. Each remainder is a digit; each quotient is fed back as the next dividend.
- Sits between the value source (counter/ADC logic) and the display multiplexer. Owns the divider's start/value inputs exclusively.

Parameters:
- DIGITS, 4, number of BCD digits produced (legal 1..4); max convertible value is 10^DIGITS-1.
- VALUE_W, 14, width of the binary input and of the divider dividend.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request conversion of value; sampled only in IDLE.
- value  in  VALUE_W  binary input, captured on the accepted start edge.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse; digits valid from this cycle.
- overflow  out  1  latched high if the captured value exceeded 10^DIGITS-1; cleared on the next accepted start.
- digits  out  4*DIGITS  packed BCD; digit0 (ones) in [3:0].
- div_start  out  1  divider start strobe.
- div_value  out  VALUE_W  divider dividend.
- div_quotient  in  10  divider quotient.
- div_remainder  in  4  divider remainder.
- div_ready  in  1  divider result valid (level; stays high until next start).

Behaviour:
- Reset (async, rst=0): state=IDLE; busy=0, done=0, overflow=0, digits=0, div_start=0, div_value=0; digit counter=0. Reset mid-conversion aborts immediately. No done is produced for the aborted request.
- States: IDLE, LOAD, WAIT, FINISH.
- IDLE: start=1 at edge → capture value.
  - value>10^DIGITS-1 → overflow=1, digits=all 4'h9, go FINISH. Divider is not started.
  - Otherwise → div_value=value, digit counter=0, digit shift register cleared, busy=1, go LOAD.
- LOAD: div_start=1 for exactly one cycle → WAIT. div_start is 0 in all other states.
- WAIT: div_ready is not inspected until the cycle after LOAD. The divider clears ready on the load edge, so a stale ready from the previous op is never seen.
  - On div_ready=1: shift div_remainder into the digit register from the top ({rem, reg[4*DIGITS-1:4]}); div_value={zero-extend div_quotient}; counter+1.
  - If counter reaches DIGITS → FINISH; else → LOAD.
- FINISH: digits=digit register (skipped on the overflow path); done=1 for one cycle; busy=0 → IDLE.
- Timing with the team divider: div_ready rises 11 edges after the load edge.
  - One digit = LOAD 1 + WAIT 12 = 13 cycles.
  - Normal path: done asserted 1+13*DIGITS cycles after the start-accept edge (53 for DIGITS=4).
  - Overflow path: done 1 cycle after accept.
- The next LOAD falls one cycle after ready is captured, which guarantees the divider has left its run state before the next start.
- start while busy or in FINISH is ignored; no queuing.
- digits and overflow hold their values until the next accepted start. overflow is cleared on the accept edge.
- Value 0 still runs all DIGITS divides and produces 16'h0000.

Optional Feature:
- Macro BCD_BLANK_LEADING_EN.
- Defined: in FINISH, leading zero digits above digit0 are replaced by 4'hF (blank code for the segment decoder). digit0 is never blanked. Example: 42 → 16'hFF42; 0 → 16'hFFF0. Overflow output is unaffected.
- Undefined: digits are plain BCD with zeros (42 → 16'h0042).

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_LOAD, ST_WAIT, ST_FINISH), BCD_BLANK=4'hF, MAX_VALUE per DIGITS, DIV_LATENCY=11.
- Sub-module: none inside. The divider is instantiated alongside by the parent.
- One natural helper sub-module: bcd_blank, a combinational leading-zero blanker used only under the macro.

Test Plan:
- value=1234, start pulse → done exactly 53 cycles after accept; digits=16'h1234; overflow=0; div_start seen exactly 4 times.
- value=9999 then value=0 back-to-back (start on the done cycle ignored, re-issued in IDLE) → 16'h9999, then 16'h0000.
- value=10000 → done 1 cycle after accept; overflow=1; digits=16'h9999; div_start never asserted.
- start held high continuously through a conversion → only one conversion runs; the second starts on the first IDLE edge after done.
- rst pulsed low 20 cycles into converting 5678 → all outputs 0 immediately, no done; a new start of 5678 then completes correctly.
- With BCD_BLANK_LEADING_EN: 42 → 16'hFF42; 0 → 16'hFFF0; 1000 → 16'h1000.
